// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-sequencer.
//   - FSM state encoding
//   - instruction class codes and field positions (10-bit instruction)
//   - ALU opcode constants understood by the external registered ALU
package alu_seq_pkg;

    localparam int INSTR_W = 10;
    localparam int CLS_MSB = 9;
    localparam int CLS_LSB = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_JMP  = 2'b01;
    localparam logic [1:0] CLS_JZ   = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    localparam logic [3:0] OPC_LOAD  = 4'b0000;
    localparam logic [3:0] OPC_ADD   = 4'b0001;
    localparam logic [3:0] OPC_SUB   = 4'b0010;
    localparam logic [3:0] OPC_STORE = 4'b0011;
    localparam logic [3:0] OPC_CLEAR = 4'b0100;
    localparam logic [3:0] OPC_AND   = 4'b0101;
    localparam logic [3:0] OPC_OR    = 4'b0110;
    localparam logic [3:0] OPC_NOT   = 4'b0111;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder.
//   instr_i   : raw 10-bit instruction word from program memory
//   opc_o     : ALU opcode field
//   imm_o     : immediate / jump target field
//   is_*_o    : one-hot class flags (ALU, JMP, JZ, HALT)
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic [3:0]         opc_o,
    output logic [3:0]         imm_o,
    output logic               is_alu_o,
    output logic               is_jmp_o,
    output logic               is_jz_o,
    output logic               is_halt_o
);

    logic [1:0] cls;

    assign cls       = instr_i[CLS_MSB:CLS_LSB];
    assign opc_o     = instr_i[OPC_MSB:OPC_LSB];
    assign imm_o     = instr_i[IMM_MSB:IMM_LSB];
    assign is_alu_o  = (cls == CLS_ALU);
    assign is_jmp_o  = (cls == CLS_JMP);
    assign is_jz_o   = (cls == CLS_JZ);
    assign is_halt_o = (cls == CLS_HALT);

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer for an external 4-bit registered ALU.
// Fetches from a synchronous program ROM, issues ALU ops with acc on A and
// the immediate on B, writes the result back, and handles JMP/JZ/HALT.
// A step watchdog aborts programs that decode MAX_STEPS non-HALT instructions.
//   Clk, Rst_n          : clock, async active-low reset
//   start               : begin execution at pc=0 (ignored while busy)
//   busy/done/error     : run status; done/error are one-cycle pulses
//   pm_addr / pm_data   : program ROM address / data (data valid next cycle)
//   alu_opc/alu_a/alu_b : ALU operands; alu_result/alu_z : ALU outputs
//   acc                 : accumulator
//   out_valid/out_data  : store-instruction strobe and value
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MAX_STEPS = 64,
    parameter int PC_W      = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [PC_W-1:0]    pm_addr,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [3:0]         alu_opc,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    input  logic [3:0]         alu_result,
    input  logic               alu_z,
    output logic [3:0]         acc,
    output logic               out_valid,
    output logic [3:0]         out_data
);

    localparam logic [7:0] MAX_STEPS_L = 8'(MAX_STEPS);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [3:0]      acc_q;
    logic            zflag_q;
    logic [7:0]      steps_q;
    logic [7:0]      steps_d;
    logic            store_q;
    logic            busy_q, done_q, error_q, out_valid_q;
    logic [3:0]      out_data_q, alu_opc_q, alu_b_q;

    logic [3:0] dec_opc, dec_imm;
    logic       dec_alu, dec_jmp, dec_jz, dec_halt;

    alu_seq_decode u_decode (
        .instr_i   (pm_data),
        .opc_o     (dec_opc),
        .imm_o     (dec_imm),
        .is_alu_o  (dec_alu),
        .is_jmp_o  (dec_jmp),
        .is_jz_o   (dec_jz),
        .is_halt_o (dec_halt)
    );

    assign steps_d = steps_q + 8'd1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            acc_q       <= '0;
            zflag_q     <= 1'b0;
            steps_q     <= '0;
            store_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            alu_opc_q   <= OPC_STORE;
            alu_b_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        pc_q    <= '0;
                        steps_q <= '0;
                    end
                end
                // pm_addr follows pc, so the ROM samples it at the end of FETCH
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    steps_q <= steps_d;
                    store_q <= (dec_opc == OPC_STORE);
                    // A HALT landing exactly on the last allowed step still completes
                    if (steps_d == MAX_STEPS_L && !dec_halt) begin
                        state_q <= S_ERR;
                    end else if (dec_alu) begin
                        // Operands are registered here so they are stable throughout EXEC
                        alu_opc_q <= dec_opc;
                        alu_b_q   <= dec_imm;
                        state_q   <= S_EXEC;
                    end else if (dec_jmp) begin
                        pc_q    <= PC_W'(dec_imm);
                        state_q <= S_FETCH;
                    end else if (dec_jz) begin
                        pc_q    <= zflag_q ? PC_W'(dec_imm) : pc_q + PC_W'(1);
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_EXEC: begin
                    // Back to pass-through so the ALU keeps mirroring acc
                    alu_opc_q <= OPC_STORE;
                    alu_b_q   <= '0;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    acc_q   <= alu_result;
                    zflag_q <= alu_z;
                    pc_q    <= pc_q + PC_W'(1);
                    if (store_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_q;
                    end
                    state_q <= S_FETCH;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign pm_addr   = pc_q;
    assign alu_opc   = alu_opc_q;
    assign alu_a     = acc_q;
    assign alu_b     = alu_b_q;
    assign acc       = acc_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
